// File: rtl/cpu_pkg.sv
// Shared decode encodings and the pipeline-stage entry carried by dest_tracker.
package cpu_pkg;

  localparam logic [1:0] DEST_NONE = 2'b00;
  localparam logic [1:0] DEST_RT   = 2'b01;
  localparam logic [1:0] DEST_RD   = 2'b10;
  localparam logic [1:0] DEST_LINK = 2'b11;

  localparam int unsigned LINK_REG_DEF = 31;
  localparam logic [2:0]  FWD_RF       = 3'd0;

  // Fields are sized for the widest legal configuration; narrower builds zero-extend.
  localparam int unsigned ADDR_MAX_W = 8;
  localparam int unsigned TNEW_MAX_W = 4;

  typedef struct packed {
    logic [ADDR_MAX_W-1:0] addr;
    logic                  we;
    logic [TNEW_MAX_W-1:0] tnew;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '{addr: '0, we: 1'b0, tnew: '0};

endpackage

// File: rtl/dest_hazard_match.sv
// Single-source priority scan over the tracked stages: youngest match decides stall/forward.
module dest_hazard_match
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned STAGES = 3,
  parameter int unsigned TNEW_W = 2
) (
  input  stage_t [STAGES-1:0] stages_i,
  input  logic [ADDR_W-1:0]   src_i,
  input  logic [TNEW_W-1:0]   tuse_i,
  output logic                stall_o,
  output logic [2:0]          fwd_o
);

  logic [ADDR_MAX_W-1:0] src_ext_s;
  logic [TNEW_MAX_W-1:0] tuse_ext_s;
  logic                  found_s;

  always_comb begin
    src_ext_s               = '0;
    src_ext_s[ADDR_W-1:0]   = src_i;
    tuse_ext_s              = '0;
    tuse_ext_s[TNEW_W-1:0]  = tuse_i;
    stall_o                 = 1'b0;
    fwd_o                   = FWD_RF;
    found_s                 = 1'b0;
    if (src_i != '0) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (!found_s && stages_i[k].we && (stages_i[k].addr == src_ext_s)) begin
          found_s = 1'b1;
          if (stages_i[k].tnew == '0) begin
            fwd_o = 3'(k + 1);
          end else if (stages_i[k].tnew > tuse_ext_s) begin
            stall_o = 1'b1;
          end else begin
            // Producer will be ready in time; forwarding happens once it ages.
            fwd_o = FWD_RF;
          end
        end else begin
          found_s = found_s;
        end
      end
    end else begin
      found_s = 1'b0;
    end
  end

endmodule

// File: rtl/dest_tracker.sv
// Tracks D-stage destination registers with their Tnew through E..W, answers hazard queries
// and drives the register-file write port from the last stage.
module dest_tracker
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned STAGES   = 3,
  parameter int unsigned LINK_REG = LINK_REG_DEF,
  parameter int unsigned TNEW_W   = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              d_valid,
  input  logic [ADDR_W-1:0] d_rt,
  input  logic [ADDR_W-1:0] d_rd,
  input  logic [1:0]        d_sel,
  input  logic [TNEW_W-1:0] d_tnew,
  input  logic              stall_in,
  input  logic              flush_e,
  input  logic [ADDR_W-1:0] q_rs,
  input  logic [ADDR_W-1:0] q_rt,
  input  logic [TNEW_W-1:0] q_tuse_rs,
  input  logic [TNEW_W-1:0] q_tuse_rt,
  output logic              stall_req,
  output logic [2:0]        fwd_rs,
  output logic [2:0]        fwd_rt,
  output logic [ADDR_W-1:0] wb_addr,
  output logic              wb_en
);

  stage_t [STAGES-1:0] stage_q;
  stage_t [STAGES-1:0] stage_d;
  logic [ADDR_W-1:0]   dec_addr_s;
  logic                dec_we_s;
  stage_t              dec_entry_s;
  logic                stall_rs_s;
  logic                stall_rt_s;

  always_comb begin
    case (d_sel)
      DEST_NONE: dec_addr_s = '0;
      DEST_RT:   dec_addr_s = d_rt;
      DEST_RD:   dec_addr_s = d_rd;
      DEST_LINK: dec_addr_s = ADDR_W'(LINK_REG);
      default:   dec_addr_s = '0;
    endcase
    dec_we_s = d_valid && (d_sel != DEST_NONE) && (dec_addr_s != '0);
    dec_entry_s = STAGE_BUBBLE;
    if (dec_we_s) begin
      dec_entry_s.addr[ADDR_W-1:0] = dec_addr_s;
      dec_entry_s.we               = 1'b1;
      dec_entry_s.tnew[TNEW_W-1:0] = d_tnew;
    end else begin
      dec_entry_s = STAGE_BUBBLE;
    end
  end

  // Stage 0 takes a bubble on stall or flush; older stages always shift and age.
  always_comb begin
    stage_d = stage_q;
    if (stall_in || flush_e) begin
      stage_d[0] = STAGE_BUBBLE;
    end else begin
      stage_d[0] = dec_entry_s;
    end
    for (int k = 1; k < int'(STAGES); k++) begin
      stage_d[k] = stage_q[k-1];
      if (stage_q[k-1].tnew != '0) begin
        stage_d[k].tnew = stage_q[k-1].tnew - TNEW_MAX_W'(1);
      end else begin
        stage_d[k].tnew = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_q <= {STAGES{STAGE_BUBBLE}};
    end else begin
      stage_q <= stage_d;
    end
  end

  dest_hazard_match #(.ADDR_W(ADDR_W), .STAGES(STAGES), .TNEW_W(TNEW_W)) u_match_rs (
    .stages_i (stage_q),
    .src_i    (q_rs),
    .tuse_i   (q_tuse_rs),
    .stall_o  (stall_rs_s),
    .fwd_o    (fwd_rs)
  );

  dest_hazard_match #(.ADDR_W(ADDR_W), .STAGES(STAGES), .TNEW_W(TNEW_W)) u_match_rt (
    .stages_i (stage_q),
    .src_i    (q_rt),
    .tuse_i   (q_tuse_rt),
    .stall_o  (stall_rt_s),
    .fwd_o    (fwd_rt)
  );

  assign stall_req = stall_rs_s | stall_rt_s;
  assign wb_addr   = stage_q[STAGES-1].addr[ADDR_W-1:0];
  assign wb_en     = stage_q[STAGES-1].we;

endmodule
